// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversamples CS/SCLK/MOSI in the clk domain, deserialises
// each frame onto a valid/data output and shifts a preloaded reply word out on MISO.
module spi_peripheral #(
    parameter int TRANSACTION_LENGTH_BITS = 32,
    parameter int SYNC_STAGES             = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               spi_cs_n,
    input  logic                               spi_clk,
    input  logic                               spi_din,
    output logic                               spi_dout,
    input  logic                               axiiv,
    input  logic [TRANSACTION_LENGTH_BITS-1:0] axiid,
    output logic                               axiready,
    output logic                               axiov,
    output logic [TRANSACTION_LENGTH_BITS-1:0] axiod,
    output logic                               frame_error
);
    localparam int N  = TRANSACTION_LENGTH_BITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, din_s;
    logic                   cs_rise, cs_fall, sclk_rise, sclk_fall, last_bit;
    logic [N-1:0]           rx_shift, tx_shift, reply_buf;
    logic [CW-1:0]          bit_cnt;

    // CS idles high, so its synchroniser resets high to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            din_sync  <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], spi_din};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign last_bit  = sclk_rise && (bit_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            reply_buf   <= '0;
            axiready    <= 1'b1;
            axiov       <= 1'b0;
            axiod       <= '0;
            frame_error <= 1'b0;
            spi_dout    <= 1'b0;
        end else begin
            axiov       <= 1'b0;
            frame_error <= 1'b0;

            if (axiiv && axiready) begin
                reply_buf <= axiid;
                axiready  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    spi_dout <= 1'b0;
                    if (cs_fall) begin
                        // axiready high means the buffer is empty: send zeros. A load in
                        // this same cycle stays buffered for the following frame.
                        tx_shift <= axiready ? '0 : reply_buf;
                        spi_dout <= ~axiready & reply_buf[N-1];
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                        if (!(axiiv && axiready))
                            axiready <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (bit_cnt == CW'(N)) begin
                        axiod    <= rx_shift;
                        axiov    <= 1'b1;
                        spi_dout <= 1'b0;
                        // CS may already be high if it rose with the final SCLK edge.
                        state    <= cs_s ? IDLE : OVERRUN;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[N-2:0], din_s};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                        if (sclk_fall) begin
                            tx_shift <= {tx_shift[N-2:0], 1'b0};
                            spi_dout <= tx_shift[N-2];
                        end
                        if (cs_rise && !last_bit) begin
                            frame_error <= 1'b1;
                            spi_dout    <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end

                OVERRUN: begin
                    spi_dout <= 1'b0;
                    if (cs_rise)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the far end of the team's spi_controller link, e.g. a second board or a debug FPGA receiving the 32-bit match-score stream.
- Oversamples spi_cs_n and spi_clk in the system clock domain and deserialises each frame onto an AXI-style valid/data output.
- Simultaneously shifts a preloaded reply word out on MISO.

Parameters:
- TRANSACTION_LENGTH_BITS, 32: bits per frame, for both receive and transmit.
- SYNC_STAGES, 2: flip-flop synchroniser depth on spi_cs_n, spi_clk and spi_din. Minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- spi_cs_n  input  1  chip select from controller, active low.
- spi_clk  input  1  SPI clock from controller.
- spi_din  input  1  MOSI (controller's spi_dout).
- spi_dout  output  1  MISO (controller's spi_din).
- axiiv  input  1  reply word valid.
- axiid  input  TRANSACTION_LENGTH_BITS  reply word.
- axiready  output  1  reply buffer empty; may accept axiid.
- axiov  output  1  one-cycle pulse: received word valid.
- axiod  output  TRANSACTION_LENGTH_BITS  received word; held until next axiov.
- frame_error  output  1  one-cycle pulse: frame ended short.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous and active low; all registers clear immediately when it is asserted.
  - Reset values: axiov=0, axiod=0, frame_error=0, spi_dout=0, axiready=1, state=IDLE, bit counter=0, reply buffer empty.
- Input conditioning:
  - spi_cs_n, spi_clk and spi_din each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronised stage with one further delayed copy (rise/fall flags, each one cycle wide).
  - Supported SCLK frequency: at most clk/8. Faster SCLK is unsupported and untested.
- States: IDLE, SHIFT, OVERRUN.
- IDLE:
  - spi_dout=0.
  - On the synchronised CS falling edge: move the reply buffer into the tx shift register (all zeros if the buffer is empty), mark the buffer empty, drive spi_dout=tx[MSB], clear the bit counter, go to SHIFT.
- SHIFT:
  - On synchronised SCLK rise: rx_shift <= {rx_shift[N-2:0], synced spi_din}; counter++.
  - On synchronised SCLK fall: shift tx left and present the next bit on spi_dout.
  - When the counter reaches TRANSACTION_LENGTH_BITS on a rise, the next cycle sets axiod <= the completed rx word and axiov=1 for exactly one cycle, then goes to OVERRUN.
  - CS rising before the count completes: pulse frame_error one cycle, discard partial data (axiod unchanged, no axiov), go to IDLE.
- OVERRUN:
  - Extra SCLK edges are ignored; spi_dout=0.
  - CS rise returns to IDLE. No error is flagged for extra clocks.
- Same-cycle CS rise and final SCLK rise: the final bit counts; the frame completes normally (axiov, no frame_error).
- Reply handshake:
  - A transfer occurs when axiiv && axiready. The buffer then loads axiid and axiready drops the next cycle.
  - axiready rises again the cycle after the buffer is consumed at a CS fall.
  - If a load coincides with a CS fall, the CS fall consumes the old buffer contents (zeros if empty), and the new word is held for the next frame.
  - axiiv while axiready=0 is ignored.
- axiov and frame_error are never asserted in the same cycle.

Test Plan:
- Full frame: reset, preload reply 0xA5A5_0F0F; controller sends 0xDEADBEEF at SCLK=clk/100 → single axiov pulse with axiod=0xDEADBEEF; MISO bits sampled by the controller = 0xA5A5_0F0F; axiready=1 after the CS fall.
- No preload: a frame with an empty reply buffer → MISO all zeros; axiod equals the MOSI word.
- Short frame: CS raised after 17 bits → one frame_error pulse; no axiov; axiod keeps the previous value. A following full frame of 0x00000001 → axiov with axiod=0x00000001.
- Overrun: 40 SCLK pulses in one CS window with the first 32 bits = 0x12345678 → exactly one axiov with 0x12345678; no frame_error.
- Back-to-back: two frames 0x11111111 then 0x22222222 with 8 clk cycles of CS high between them, reply reloaded between frames → two axiov pulses in order; the second reply word is shifted out correctly.
- Async reset mid-frame: assert rst_n=0 after 10 bits → outputs take reset values immediately. A clean frame after release (with CS high first) receives correctly, with no spurious axiov or frame_error.
